// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage front end for data_mem; checks, issues and returns extended loads
module load_store_unit #(
  parameter int MEMORY_SIZE = 12288,
  parameter int ADDR_WIDTH = $clog2(MEMORY_SIZE),
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [3:0]            mem_byteena,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  localparam int CW = $clog2(READ_LATENCY + 1);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] lat_f3;
  logic [1:0] lat_off, off;
  logic accept, legal, aligned, ok;
  logic [7:0] sel_b;
  logic [15:0] sel_h;
  logic [31:0] ext;
  always_comb begin
    off = req_addr[1:0];
    req_ready = state == S_IDLE && !rst;
    accept = req_valid && req_ready;
    legal = req_we ? req_funct3 inside {3'b000, 3'b001, 3'b010}
                   : req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    aligned = req_funct3[1:0] == 2'b00 || (req_funct3[1:0] == 2'b01 && !off[0]) ||
              (req_funct3[1:0] == 2'b10 && off == 2'b00);
    ok = accept && legal && aligned;
    mem_addr = req_addr;
    mem_we = ok && req_we;
    mem_re = ok && !req_we;
    mem_byteena = (!req_we || req_funct3[1:0] == 2'b10) ? 4'b1111 :
                  req_funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b0001 << off;
    mem_wdata = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    sel_b = mem_rdata[{lat_off, 3'b000} +: 8];
    sel_h = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext = lat_f3[1:0] == 2'b00 ? {{24{sel_b[7] & !lat_f3[2]}}, sel_b} :
          lat_f3[1:0] == 2'b01 ? {{16{sel_h[15] & !lat_f3[2]}}, sel_h} : mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      lat_f3 <= '0;
      lat_off <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      err_valid <= 1'b0;
      err_addr <= '0;
    end else begin
      resp_valid <= 1'b0;
      err_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (accept && !ok) begin
          err_valid <= 1'b1;
          err_addr <= req_addr;
        end else if (mem_re) begin
          lat_f3 <= req_funct3;
          lat_off <= off;
          cnt <= CW'(1);
          state <= S_WAIT;
        end
      end else if (cnt == CW'(READ_LATENCY)) begin
        resp_rdata <= ext;
        resp_valid <= 1'b1;
        state <= S_IDLE;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule
